// File: rtl/hbridge_deadtime_guard_pkg.sv
// hbridge_pkg: shared direction codes, channel FSM states and helpers for the H-bridge guard.
package hbridge_pkg;
    typedef logic [1:0] dir_t;
    localparam dir_t DIR_FWD = 2'b10;
    localparam dir_t DIR_REV = 2'b01;
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRIVE    = 2'd1,
        DEADTIME = 2'd2
    } state_t;
    function automatic logic dir_valid(input dir_t d);
        return d == DIR_FWD || d == DIR_REV;
    endfunction
endpackage

// File: rtl/hbridge_deadtime_guard_if.sv
// hbridge_deadtime_guard_if: controller-side pwm/direction inputs and bridge-side gate/status outputs for two motors.
interface hbridge_deadtime_guard_if
    import hbridge_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic motor1_pwm;
    dir_t motor1_ctrl;
    logic motor2_pwm;
    dir_t motor2_ctrl;
    logic m1_in1, m1_in2, m1_en, m1_busy;
    logic m2_in1, m2_in2, m2_en, m2_busy;
    logic [CNT_W-1:0] m1_rev_cnt, m2_rev_cnt;
    modport master (
        output motor1_pwm, motor1_ctrl, motor2_pwm, motor2_ctrl,
        input  m1_in1, m1_in2, m1_en, m1_busy, m1_rev_cnt,
        input  m2_in1, m2_in2, m2_en, m2_busy, m2_rev_cnt
    );
    modport slave (
        input  motor1_pwm, motor1_ctrl, motor2_pwm, motor2_ctrl,
        output m1_in1, m1_in2, m1_en, m1_busy, m1_rev_cnt,
        output m2_in1, m2_in2, m2_en, m2_busy, m2_rev_cnt
    );
endinterface

// File: rtl/hbridge_channel_guard.sv
// hbridge_channel_guard: one bridge channel -- input staging, dead-time FSM, dead-time counter and
// saturating reversal counter; gates are registered from the next state so they never glitch.
module hbridge_channel_guard
    import hbridge_pkg::*;
#(
    parameter int DEAD_CYCLES = 1000,
    parameter int CNT_W = 16
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             pwm,
    input  dir_t             ctrl,
    output logic             in1,
    output logic             in2,
    output logic             en,
    output logic             busy,
    output logic [CNT_W-1:0] rev_cnt
);
    localparam logic [CNT_W-1:0] DEAD = CNT_W'(DEAD_CYCLES);
    logic pwm_q, first_q, valid, differs, reload;
    dir_t ctrl_q, dir_q, dir_n;
    state_t state, state_n;
    logic [CNT_W-1:0] cnt;
    always_comb begin
        valid = dir_valid(ctrl_q);
        differs = valid && ctrl_q != dir_q;
        reload = differs && (state != IDLE || !first_q);
        dir_n = valid ? ctrl_q : dir_q;
        state_n = !valid ? IDLE : reload ? DEADTIME :
                  (state == DEADTIME && cnt != CNT_W'(1)) ? DEADTIME : DRIVE;
    end
    // Staging regs clear under reset so the first command after release still takes two edges.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            pwm_q   <= 1'b0;
            ctrl_q  <= 2'b00;
            state   <= IDLE;
            dir_q   <= DIR_FWD;
            cnt     <= '0;
            rev_cnt <= '0;
            first_q <= 1'b1;
            in1     <= 1'b0;
            in2     <= 1'b0;
            en      <= 1'b0;
            busy    <= 1'b0;
        end else begin
            pwm_q  <= pwm;
            ctrl_q <= ctrl;
            state  <= state_n;
            dir_q  <= dir_n;
            if (reload)
                cnt <= DEAD;
            else if (state == DEADTIME)
                cnt <= cnt - CNT_W'(1);
            if (reload && !(&rev_cnt))
                rev_cnt <= rev_cnt + CNT_W'(1);
            if (state == IDLE && state_n == DRIVE)
                first_q <= 1'b0;
            in1  <= state_n == DRIVE && dir_n[1];
            in2  <= state_n == DRIVE && dir_n[0];
            en   <= state_n == DRIVE && pwm_q;
            busy <= state_n == DEADTIME;
        end
    end
    assert property (@(posedge PCLK) !(in1 && in2));
endmodule

// File: rtl/hbridge_deadtime_guard.sv
// hbridge_deadtime_guard: two independent dead-time guarded H-bridge channels between the
// motor controller and the bridge pins.
module hbridge_deadtime_guard #(
    parameter int DEAD_CYCLES = 1000,
    parameter int CNT_W = 16
) (
    input logic                     PCLK,
    input logic                     PRESET,
    hbridge_deadtime_guard_if.slave bus
);
    hbridge_channel_guard #(.DEAD_CYCLES(DEAD_CYCLES), .CNT_W(CNT_W)) u_m1 (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .pwm     (bus.motor1_pwm),
        .ctrl    (bus.motor1_ctrl),
        .in1     (bus.m1_in1),
        .in2     (bus.m1_in2),
        .en      (bus.m1_en),
        .busy    (bus.m1_busy),
        .rev_cnt (bus.m1_rev_cnt)
    );
    hbridge_channel_guard #(.DEAD_CYCLES(DEAD_CYCLES), .CNT_W(CNT_W)) u_m2 (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .pwm     (bus.motor2_pwm),
        .ctrl    (bus.motor2_ctrl),
        .in1     (bus.m2_in1),
        .in2     (bus.m2_in2),
        .en      (bus.m2_en),
        .busy    (bus.m2_busy),
        .rev_cnt (bus.m2_rev_cnt)
    );
endmodule

// File: tb/tb_hbridge_deadtime_guard.sv
// tb_hbridge_deadtime_guard: two guards (DEAD_CYCLES=8/CNT_W=16 and DEAD_CYCLES=1/CNT_W=4) driven
// identically; a behavioural model feeds a per-edge scoreboard, plus directed dead-time checks.
module tb_hbridge_deadtime_guard;
    logic PCLK = 1'b0;
    logic PRESET = 1'b1;
    logic p1 = 1'b0, p2 = 1'b0;
    logic [1:0] c1 = 2'b00, c2 = 2'b00;
    int checks = 0, failures = 0, cycle = 0, off_a = 0, off_b = 0;
    int m_st[4], m_cn[4], m_rc[4];
    logic [1:0] m_dq[4], m_cq[4];
    logic m_pq[4], m_fq[4];
    logic [3:0][19:0] sb[$];

    always #5 PCLK = ~PCLK;

    hbridge_deadtime_guard_if #(.CNT_W(16)) bus_a ();
    hbridge_deadtime_guard_if #(.CNT_W(4)) bus_b ();
    hbridge_deadtime_guard #(.DEAD_CYCLES(8), .CNT_W(16)) dut_a (.PCLK(PCLK), .PRESET(PRESET), .bus(bus_a));
    hbridge_deadtime_guard #(.DEAD_CYCLES(1), .CNT_W(4)) dut_b (.PCLK(PCLK), .PRESET(PRESET), .bus(bus_b));

    task automatic reverse(input int c);
        m_st[c] = 2;
        m_dq[c] = m_cq[c];
        m_cn[c] = (c < 2) ? 8 : 1;
        if (m_rc[c] < ((c < 2) ? 65535 : 15)) m_rc[c]++;
    endtask

    // Behaviour of one channel at one edge, given the inputs presented before that edge.
    task automatic model(input int c, input logic p, input logic [1:0] ct, output logic [19:0] o);
        logic v, d, ep;
        ep = m_pq[c];
        if (PRESET) begin
            m_st[c] = 0; m_dq[c] = 2'b10; m_cn[c] = 0; m_rc[c] = 0; m_fq[c] = 1'b1;
        end else begin
            v = (m_cq[c] == 2'b10) || (m_cq[c] == 2'b01);
            d = v && (m_cq[c] != m_dq[c]);
            case (m_st[c])
                0: if (v) begin
                    if (d && !m_fq[c]) reverse(c);
                    else begin m_st[c] = 1; m_dq[c] = m_cq[c]; m_fq[c] = 1'b0; end
                end
                1: if (!v) m_st[c] = 0; else if (d) reverse(c);
                default: if (!v) m_st[c] = 0; else if (d) reverse(c);
                         else if (m_cn[c] == 1) m_st[c] = 1; else m_cn[c]--;
            endcase
        end
        o = {m_st[c] == 1 && m_dq[c][1], m_st[c] == 1 && m_dq[c][0], m_st[c] == 1 && ep, m_st[c] == 2, 16'(m_rc[c])};
        m_pq[c] = PRESET ? 1'b0 : p;
        m_cq[c] = PRESET ? 2'b00 : ct;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        logic [3:0][19:0] f, e, o;
        for (int k = 0; k < n; k++) begin
            bus_a.motor1_pwm = p1; bus_a.motor1_ctrl = c1; bus_a.motor2_pwm = p2; bus_a.motor2_ctrl = c2;
            bus_b.motor1_pwm = p1; bus_b.motor1_ctrl = c1; bus_b.motor2_pwm = p2; bus_b.motor2_ctrl = c2;
            model(0, p1, c1, f[0]);
            model(1, p2, c2, f[1]);
            model(2, p1, c1, f[2]);
            model(3, p2, c2, f[3]);
            sb.push_back(f);
            @(posedge PCLK);
            #1;
            e = sb.pop_front();
            o[0] = {bus_a.m1_in1, bus_a.m1_in2, bus_a.m1_en, bus_a.m1_busy, bus_a.m1_rev_cnt};
            o[1] = {bus_a.m2_in1, bus_a.m2_in2, bus_a.m2_en, bus_a.m2_busy, bus_a.m2_rev_cnt};
            o[2] = {bus_b.m1_in1, bus_b.m1_in2, bus_b.m1_en, bus_b.m1_busy, 12'd0, bus_b.m1_rev_cnt};
            o[3] = {bus_b.m2_in1, bus_b.m2_in2, bus_b.m2_en, bus_b.m2_busy, 12'd0, bus_b.m2_rev_cnt};
            for (int c = 0; c < 4; c++) begin
                checks++;
                assert (o[c] === e[c]) else begin
                    failures++;
                    $error("FAIL sb_ch%0d cycle=%0d observed=%h expected=%h", c, cycle, o[c], e[c]);
                end
            end
            off_a += int'(bus_a.m1_busy);
            off_b += int'(bus_b.m1_busy);
            cycle++;
        end
    endtask

    initial begin
        for (int c = 0; c < 4; c++) begin
            m_st[c] = 0; m_cn[c] = 0; m_rc[c] = 0; m_dq[c] = 2'b10; m_cq[c] = 2'b00; m_pq[c] = 1'b0; m_fq[c] = 1'b1;
        end
        // reset with a FWD command already present
        PRESET = 1'b1; c1 = 2'b10; p1 = 1'b1; c2 = 2'b01; p2 = 1'b1;
        cyc(3);
        check("reset_in1", int'(bus_a.m1_in1), 0);
        check("reset_en", int'(bus_a.m1_en), 0);
        check("reset_rev", int'(bus_a.m1_rev_cnt), 0);
        PRESET = 1'b0;
        cyc(1);
        check("first_cmd_edge1_in1", int'(bus_a.m1_in1), 0);
        cyc(1);
        check("first_cmd_edge2_in1", int'(bus_a.m1_in1), 1);
        check("first_cmd_rev_in2", int'(bus_a.m2_in2), 1);
        check("first_cmd_no_busy", int'(bus_a.m1_busy), 0);
        // FWD drive with pwm toggling
        for (int i = 0; i < 4; i++) begin
            p1 = ~p1;
            cyc(5);
        end
        // reversal on both channels on the same edge
        p1 = 1'b1; c1 = 2'b01; c2 = 2'b10; off_a = 0; off_b = 0;
        cyc(12);
        check("rev_off_cycles", off_a, 8);
        check("rev_off_cycles_dead1", off_b, 1);
        check("rev_in2", int'(bus_a.m1_in2), 1);
        check("rev_en", int'(bus_a.m1_en), 1);
        check("rev_cnt1", int'(bus_a.m1_rev_cnt), 1);
        check("rev_cnt_m2", int'(bus_a.m2_rev_cnt), 1);
        // re-reversal four cycles into dead-time
        off_a = 0; c1 = 2'b10;
        cyc(4);
        c1 = 2'b01;
        cyc(20);
        check("rerev_off_cycles", off_a, 12);
        check("rerev_in2", int'(bus_a.m1_in2), 1);
        check("rerev_cnt", int'(bus_a.m1_rev_cnt), 3);
        // illegal code coasts, same direction resumes without dead-time
        c1 = 2'b11;
        cyc(2);
        check("coast_in2", int'(bus_a.m1_in2), 0);
        check("coast_en", int'(bus_a.m1_en), 0);
        check("coast_busy", int'(bus_a.m1_busy), 0);
        off_a = 0; c1 = 2'b01;
        cyc(3);
        check("resume_no_dead", off_a, 0);
        check("resume_in2", int'(bus_a.m1_in2), 1);
        c1 = 2'b00;
        cyc(3);
        off_a = 0; c1 = 2'b10;
        cyc(12);
        check("coast_then_rev_off", off_a, 8);
        check("coast_then_rev_in1", int'(bus_a.m1_in1), 1);
        check("coast_then_rev_cnt", int'(bus_a.m1_rev_cnt), 4);
        // reset in the middle of dead-time
        c1 = 2'b01;
        cyc(5);
        check("pre_reset_busy", int'(bus_a.m1_busy), 1);
        PRESET = 1'b1;
        cyc(1);
        check("mid_reset_busy", int'(bus_a.m1_busy), 0);
        check("mid_reset_rev", int'(bus_a.m1_rev_cnt), 0);
        PRESET = 1'b0;
        cyc(3);
        check("post_reset_in2", int'(bus_a.m1_in2), 1);
        // 20 back-to-back reversals: 4-bit counter saturates
        for (int i = 0; i < 20; i++) begin
            c1 = (i % 2 == 0) ? 2'b10 : 2'b01;
            cyc(1);
        end
        cyc(2);
        check("sat_cnt_w4", int'(bus_b.m1_rev_cnt), 15);
        check("cnt_w16_20", int'(bus_a.m1_rev_cnt), 20);
        cyc(12);
        check("final_in2", int'(bus_a.m1_in2), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
